vga_timing_gen: RTL and testbench
=================================

// Module: vga_timing_gen
// PURPOSE
//   Parametrised VGA/SVGA raster timing generator; replaces the fixed 800x600@60 Hz counter block.
//   Generates pixel coordinates plus active-area, sync and frame/line markers for any mode.
//   Pixel-clock enable and a sync/DE delay line keep sync aligned with downstream pixel-pipeline latency.
//   Sits between the clock source and the pong renderer / VGA output pins.
// PARAMETERS
//   H_ACTIVE   800  visible pixels per line
//   H_FP       40   horizontal front porch, pixels
//   H_SYNC     128  horizontal sync width, pixels
//   H_BP       88   horizontal back porch, pixels
//   V_ACTIVE   600  visible lines per frame
//   V_FP       1    vertical front porch, lines
//   V_SYNC     4    vertical sync width, lines
//   V_BP       23   vertical back porch, lines
//   H_POL      1    Hsync active level (1 = positive)
//   V_POL      1    Vsync active level (1 = positive)
//   PIPE_DELAY 0    extra enabled-cycle delay on Hsync/Vsync/CanvasValid (0..15)
//   CW         12   coordinate counter width; must hold H_TOTAL-1 and V_TOTAL-1
// PORTS
//   CLK40MHZ         in   1      pixel clock (defaults = 800x600@60 at 40 MHz)
//   RESETN           in   1      asynchronous active-low reset
//   PixelEn          in   1      pixel clock enable; all state advances only when 1
//   HorizontalIndex  out  CW     current column counter, 0..H_TOTAL-1
//   VerticalIndex    out  CW     current line counter, 0..V_TOTAL-1
//   CanvasValid      out  1      active-video (DE), delayed 1+PIPE_DELAY enabled cycles
//   Hsync            out  1      horizontal sync, polarity H_POL, same delay as CanvasValid
//   Vsync            out  1      vertical sync, polarity V_POL, same delay as CanvasValid
//   LineStart        out  1      high while HorizontalIndex==0 and PixelEn==1
//   FrameStart       out  1      high while both indices==0 and PixelEn==1
//   FrameCount       out  16     frames completed, wraps 0xFFFF->0
// BEHAVIOUR
//   - H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP; V_TOTAL likewise.
//     Defaults give 1056 x 628 exactly (no extra count).
//   - Reset (async, RESETN=0): indices=0, FrameCount=0, CanvasValid=0, Hsync=~H_POL, Vsync=~V_POL.
//     Every delay-line stage is loaded with the same inactive values.
//   - Counting on PixelEn=1: H increments; at H_TOTAL-1, H wraps to 0 and V increments.
//     At (H_TOTAL-1, V_TOTAL-1) both wrap to 0 and FrameCount increments.
//   - PixelEn=0: every register holds, including the delay line. LineStart/FrameStart are 0.
//   - Decode from the current indices (h,v), registered into stage 0 on PixelEn:
//     de = h<H_ACTIVE && v<V_ACTIVE
//     hs = H_ACTIVE+H_FP <= h < H_ACTIVE+H_FP+H_SYNC
//     vs = V_ACTIVE+V_FP <= v < V_ACTIVE+V_FP+V_SYNC (whole lines)
//     Sync outputs drive H_POL/V_POL when hs/vs=1, otherwise the inverse.
//   - Latency: de/hs/vs for index (h,v) appear on the outputs 1+PIPE_DELAY enabled cycles later.
//     Indices themselves have zero latency (they are the counter registers).
//   - LineStart/FrameStart: combinational from counter registers AND PixelEn; exactly one enabled cycle each.
//     First FrameStart occurs on the first PixelEn=1 cycle after reset release.
//   - Reset mid-frame: outputs go to reset values immediately; restart at (0,0) on release.
//   - Out-of-range parameters (total exceeding 2^CW, PIPE_DELAY>15): $error at elaboration.
// TESTING
//   - Small mode H=8/2/2/4, V=4/1/1/2, PixelEn=1, PIPE_DELAY=0.
//     Expect H wraps 15->0, V wraps 7->0.
//     Expect Hsync high for exactly 2 cycles, starting the cycle after H==10.
//     Expect CanvasValid high 8 of every 16 cycles on lines 0..3 only.
//   - Same mode, H_POL=0 V_POL=0, held in reset.
//     Expect Hsync=Vsync=1, CanvasValid=0.
//     After release, expect FrameStart=1 on the first cycle and FrameCount=1 after 128 cycles.
//   - PIPE_DELAY=3: expect each Hsync/CanvasValid edge exactly 3 cycles later than with PIPE_DELAY=0.
//     Expect indices unchanged.
//   - PixelEn toggling 1,0,1,0: expect counters to advance only on enabled cycles.
//     Expect one full frame to take 256 CLK cycles.
//     Expect FrameStart pulse width = 1 CLK.
//   - Defaults at 40 MHz: expect line = 1056 cycles and frame = 663168 cycles.
//     Expect Hsync active on h 840..967 and Vsync active on v 601..604.
//   - Force FrameCount=0xFFFF at end of frame: expect wrap to 0.
//     Assert RESETN low mid-line: expect async clear with no clock edge.

Source files
------------

// File: rtl/vga_timing_gen.sv
// Parametrised raster timing generator: pixel coordinates, DE/sync with a configurable delay line, line/frame markers.
// All state advances only on PixelEn; sync/DE lag the indices by 1+PIPE_DELAY enabled cycles.
module vga_timing_gen #(
  parameter int H_ACTIVE   = 800,
  parameter int H_FP       = 40,
  parameter int H_SYNC     = 128,
  parameter int H_BP       = 88,
  parameter int V_ACTIVE   = 600,
  parameter int V_FP       = 1,
  parameter int V_SYNC     = 4,
  parameter int V_BP       = 23,
  parameter bit H_POL      = 1'b1,
  parameter bit V_POL      = 1'b1,
  parameter int PIPE_DELAY = 0,
  parameter int CW         = 12
) (
  input  logic          CLK40MHZ,
  input  logic          RESETN,
  input  logic          PixelEn,
  output logic [CW-1:0] HorizontalIndex,
  output logic [CW-1:0] VerticalIndex,
  output logic          CanvasValid,
  output logic          Hsync,
  output logic          Vsync,
  output logic          LineStart,
  output logic          FrameStart,
  output logic [15:0]   FrameCount
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int NST     = PIPE_DELAY + 1;

  if (H_TOTAL > 2**CW || V_TOTAL > 2**CW) begin : g_bad_cw
    $error("vga_timing_gen: H_TOTAL/V_TOTAL do not fit in CW bits");
  end
  if (PIPE_DELAY < 0 || PIPE_DELAY > 15) begin : g_bad_delay
    $error("vga_timing_gen: PIPE_DELAY must be 0..15");
  end

  localparam logic [CW-1:0] H_LAST = CW'(H_TOTAL - 1);
  localparam logic [CW-1:0] V_LAST = CW'(V_TOTAL - 1);
  // Decode bounds carry an extra bit so a boundary equal to 2^CW does not alias to 0.
  localparam logic [CW:0] H_DE_END = (CW+1)'(H_ACTIVE);
  localparam logic [CW:0] H_HS_BEG = (CW+1)'(H_ACTIVE + H_FP);
  localparam logic [CW:0] H_HS_END = (CW+1)'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [CW:0] V_DE_END = (CW+1)'(V_ACTIVE);
  localparam logic [CW:0] V_VS_BEG = (CW+1)'(V_ACTIVE + V_FP);
  localparam logic [CW:0] V_VS_END = (CW+1)'(V_ACTIVE + V_FP + V_SYNC);

  logic [CW-1:0] r_h;
  logic [CW-1:0] r_v;
  logic [15:0]   r_fc;
  logic [2:0]    r_pipe [NST];  // {de, hs, vs} active-high flags per stage
  logic [CW:0]   w_hx;
  logic [CW:0]   w_vx;
  logic          w_de;
  logic          w_hs;
  logic          w_vs;

  always_ff @(posedge CLK40MHZ or negedge RESETN) begin
    if (!RESETN) begin
      r_h  <= '0;
      r_v  <= '0;
      r_fc <= '0;
    end else if (PixelEn) begin
      if (r_h == H_LAST) begin
        r_h <= '0;
        if (r_v == V_LAST) begin
          r_v  <= '0;
          r_fc <= r_fc + 16'd1;
        end else begin
          r_v <= r_v + 1'b1;
        end
      end else begin
        r_h <= r_h + 1'b1;
      end
    end
  end

  assign w_hx = {1'b0, r_h};
  assign w_vx = {1'b0, r_v};
  assign w_de = (w_hx < H_DE_END) && (w_vx < V_DE_END);
  assign w_hs = (w_hx >= H_HS_BEG) && (w_hx < H_HS_END);
  assign w_vs = (w_vx >= V_VS_BEG) && (w_vx < V_VS_END);

  always_ff @(posedge CLK40MHZ or negedge RESETN) begin
    if (!RESETN) begin
      for (int i = 0; i < NST; i++) r_pipe[i] <= 3'b000;
    end else if (PixelEn) begin
      r_pipe[0] <= {w_de, w_hs, w_vs};
      for (int i = 1; i < NST; i++) r_pipe[i] <= r_pipe[i-1];
    end
  end

  assign HorizontalIndex = r_h;
  assign VerticalIndex   = r_v;
  assign FrameCount      = r_fc;
  assign CanvasValid     = r_pipe[NST-1][2];
  assign Hsync           = r_pipe[NST-1][1] ? H_POL : ~H_POL;
  assign Vsync           = r_pipe[NST-1][0] ? V_POL : ~V_POL;
  assign LineStart       = PixelEn && (r_h == '0);
  assign FrameStart      = LineStart && (r_v == '0);

endmodule

// File: tb/tb_vga_timing_gen.sv
// Four generator instances (small/positive, small/negative+delay 3, default SVGA, 1x1 frame) checked
// cycle by cycle against an arithmetic model driven by the count of enabled clocks since reset.
module tb_vga_timing_gen;

  localparam int TOTAL  = 65700;
  localparam int MIDRST = 65600;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n;
  logic en_r;
  logic en1;

  logic [11:0] hi [4];
  logic [11:0] vi [4];
  logic        cv [4];
  logic        hs [4];
  logic        vs [4];
  logic        ls [4];
  logic        fs [4];
  logic [15:0] fc [4];

  int m_ha [4] = '{8, 8, 800, 1};
  int m_hf [4] = '{2, 2, 40, 0};
  int m_hw [4] = '{2, 2, 128, 0};
  int m_hb [4] = '{4, 4, 88, 0};
  int m_va [4] = '{4, 4, 600, 1};
  int m_vf [4] = '{1, 1, 1, 0};
  int m_vw [4] = '{1, 1, 4, 0};
  int m_vb [4] = '{2, 2, 23, 0};
  int m_hp [4] = '{1, 0, 1, 1};
  int m_vp [4] = '{1, 0, 1, 1};
  int m_pd [4] = '{0, 3, 0, 0};

  vga_timing_gen #(.H_ACTIVE(8), .H_FP(2), .H_SYNC(2), .H_BP(4), .V_ACTIVE(4), .V_FP(1), .V_SYNC(1),
                   .V_BP(2), .H_POL(1'b1), .V_POL(1'b1), .PIPE_DELAY(0), .CW(12)) u_a (
    .CLK40MHZ(clk), .RESETN(rst_n), .PixelEn(en_r), .HorizontalIndex(hi[0]), .VerticalIndex(vi[0]),
    .CanvasValid(cv[0]), .Hsync(hs[0]), .Vsync(vs[0]), .LineStart(ls[0]), .FrameStart(fs[0]),
    .FrameCount(fc[0]));

  vga_timing_gen #(.H_ACTIVE(8), .H_FP(2), .H_SYNC(2), .H_BP(4), .V_ACTIVE(4), .V_FP(1), .V_SYNC(1),
                   .V_BP(2), .H_POL(1'b0), .V_POL(1'b0), .PIPE_DELAY(3), .CW(12)) u_b (
    .CLK40MHZ(clk), .RESETN(rst_n), .PixelEn(en_r), .HorizontalIndex(hi[1]), .VerticalIndex(vi[1]),
    .CanvasValid(cv[1]), .Hsync(hs[1]), .Vsync(vs[1]), .LineStart(ls[1]), .FrameStart(fs[1]),
    .FrameCount(fc[1]));

  vga_timing_gen u_c (
    .CLK40MHZ(clk), .RESETN(rst_n), .PixelEn(en1), .HorizontalIndex(hi[2]), .VerticalIndex(vi[2]),
    .CanvasValid(cv[2]), .Hsync(hs[2]), .Vsync(vs[2]), .LineStart(ls[2]), .FrameStart(fs[2]),
    .FrameCount(fc[2]));

  vga_timing_gen #(.H_ACTIVE(1), .H_FP(0), .H_SYNC(0), .H_BP(0), .V_ACTIVE(1), .V_FP(0), .V_SYNC(0),
                   .V_BP(0), .CW(12)) u_d (
    .CLK40MHZ(clk), .RESETN(rst_n), .PixelEn(en1), .HorizontalIndex(hi[3]), .VerticalIndex(vi[3]),
    .CanvasValid(cv[3]), .Hsync(hs[3]), .Vsync(vs[3]), .LineStart(ls[3]), .FrameStart(fs[3]),
    .FrameCount(fc[3]));

  typedef struct packed {
    logic [1:0]  id;
    logic [11:0] h;
    logic [11:0] v;
    logic        de;
    logic        hsy;
    logic        vsy;
    logic        ls;
    logic        fs;
    logic [15:0] fc;
  } exp_t;

  exp_t sb [$];
  int checks = 0;
  int errors = 0;

  task automatic chk(input string nm, input int id, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s dut%0d t=%0t got %0d expected %0d", nm, id, $time, act, exp);
      if (errors >= 40) begin
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
      end
    end
  endtask

  // Expected outputs after n enabled clocks since reset, with PixelEn=en in the current cycle.
  function automatic exp_t model(input int id, input int n, input logic en);
    exp_t e;
    int   ht, vt, h, v, k, kh, kv;
    logic de, ha, va, hp, vp;
    ht = m_ha[id] + m_hf[id] + m_hw[id] + m_hb[id];
    vt = m_va[id] + m_vf[id] + m_vw[id] + m_vb[id];
    h  = n % ht;
    v  = (n / ht) % vt;
    de = 1'b0;
    ha = 1'b0;
    va = 1'b0;
    if (n >= 1 + m_pd[id]) begin
      k  = n - 1 - m_pd[id];
      kh = k % ht;
      kv = (k / ht) % vt;
      de = (kh < m_ha[id]) && (kv < m_va[id]);
      ha = (kh >= m_ha[id] + m_hf[id]) && (kh < m_ha[id] + m_hf[id] + m_hw[id]);
      va = (kv >= m_va[id] + m_vf[id]) && (kv < m_va[id] + m_vf[id] + m_vw[id]);
    end
    hp    = (m_hp[id] != 0);
    vp    = (m_vp[id] != 0);
    e.id  = 2'(id);
    e.h   = 12'(h);
    e.v   = 12'(v);
    e.de  = de;
    e.hsy = ha ? hp : ~hp;
    e.vsy = va ? vp : ~vp;
    e.ls  = en && (h == 0);
    e.fs  = en && (h == 0) && (v == 0);
    e.fc  = 16'((n / (ht * vt)) % 65536);
    return e;
  endfunction

  initial begin
    exp_t e;
    int   i;
    forever begin
      @(negedge clk);
      while (sb.size() > 0) begin
        e = sb.pop_front();
        i = int'(e.id);
        chk("hindex", i, int'(hi[i]), int'(e.h));
        chk("vindex", i, int'(vi[i]), int'(e.v));
        chk("canvas", i, int'(cv[i]), int'(e.de));
        chk("hsync", i, int'(hs[i]), int'(e.hsy));
        chk("vsync", i, int'(vs[i]), int'(e.vsy));
        chk("linestart", i, int'(ls[i]), int'(e.ls));
        chk("framestart", i, int'(fs[i]), int'(e.fs));
        chk("framecount", i, int'(fc[i]), int'(e.fc));
      end
    end
  end

  initial begin
    int   n_ab, n_cd;
    exp_t r;
    rst_n = 1'b0;
    en_r  = 1'b0;
    en1   = 1'b1;
    n_ab  = 0;
    n_cd  = 0;
    for (int c = 0; c < TOTAL; c++) begin
      @(posedge clk);
      #1;
      if (rst_n && en_r) n_ab++;
      if (rst_n) n_cd++;
      if (c == 5 || c == MIDRST + 3) rst_n = 1'b1;
      if (c == MIDRST) begin
        #2;
        rst_n = 1'b0;
        #1;
        for (int id = 0; id < 4; id++) begin
          r = model(id, 0, 1'b0);
          chk("arst_h", id, int'(hi[id]), int'(r.h));
          chk("arst_v", id, int'(vi[id]), int'(r.v));
          chk("arst_cv", id, int'(cv[id]), int'(r.de));
          chk("arst_hs", id, int'(hs[id]), int'(r.hsy));
          chk("arst_vs", id, int'(vs[id]), int'(r.vsy));
          chk("arst_fc", id, int'(fc[id]), int'(r.fc));
        end
        n_ab = 0;
        n_cd = 0;
      end
      if (c < 1000)      en_r = 1'b1;
      else if (c < 2000) en_r = (c % 2 == 0);
      else               en_r = (($urandom % 4) != 0);
      sb.push_back(model(0, n_ab, en_r));
      sb.push_back(model(1, n_ab, en_r));
      sb.push_back(model(2, n_cd, en1));
      sb.push_back(model(3, n_cd, en1));
    end
    @(negedge clk);
    #1;
    chk("drain", 0, sb.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
